// File: rtl/wr_pix_pack.sv
// -----------------------------------------------------------------------------
// wr_pix_pack
//   Packs 16-bit camera pixels into 128-bit words for the DDR write FIFO.
//   Eight pixels fill one word (pixel 0 in the low lane). Full words go into a
//   2-entry output buffer drained with a valid/ready handshake. A frame_end
//   pulse flushes any partial word with unused lanes zeroed. After the buffer
//   drains, frame_done pulses with the number of words pushed in that frame.
//   The camera cannot be stalled. A pixel offered while the packer cannot take
//   it is dropped and sets the sticky ovf flag.
//
// Ports
//   wr_clk       pixel / write clock
//   wr_rst_n     asynchronous active-low reset
//   pix_vld      pixel strobe from capture
//   pix_data     pixel value
//   frame_end    one-cycle end-of-frame pulse (last pixel on or before it)
//   pix_rdy      combinational: a pixel can be accepted this cycle
//   wr_vld       packed word valid
//   wr_data      packed word (pixel 0 in [15:0], pixel 7 in [127:112])
//   wr_rdy       downstream can take a word
//   frame_done   one-cycle pulse once the frame has fully drained
//   frame_words  words pushed in the frame, valid while frame_done = 1
//   ovf          sticky overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module wr_pix_pack #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 128,
  parameter int CNT_W = 16
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             pix_vld,
  input  logic [IN_W-1:0]  pix_data,
  input  logic             frame_end,
  output logic             pix_rdy,
  output logic             wr_vld,
  output logic [OUT_W-1:0] wr_data,
  input  logic             wr_rdy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_words,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         lane_q, lane_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   buf0_q, buf0_d;   // head entry, drives wr_data
  logic [OUT_W-1:0]   buf1_q, buf1_d;
  logic [1:0]         occ_q, occ_d;     // number of buffered words (0..2)
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               ovf_q, ovf_d;

  logic               pop_s;
  logic               full_s;
  logic               pix_rdy_s;
  logic               push_s;
  logic [OUT_W-1:0]   push_word_s;

  // Handshake terms and pixel acceptance.
  always_comb begin
    pop_s  = vld_q & wr_rdy;
    full_s = (occ_q == 2'd2);
    // The only blocking case in PACK: the 8th pixel would push into a full
    // buffer that is not being popped this cycle.
    pix_rdy_s = (state_q == ST_PACK) & ~((lane_q == 3'd7) & full_s & ~pop_s);
  end

  assign pix_rdy = pix_rdy_s;

  // Packing state machine: accumulator, lane counter, push request, frame end.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    push_s      = 1'b0;
    push_word_s = acc_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q | (pix_vld & ~pix_rdy_s);

    case (state_q)
      ST_PACK: begin
        if (pix_vld && pix_rdy_s) begin
          acc_d[IN_W*int'(lane_q) +: IN_W] = pix_data;
          if (lane_q == 3'd7) begin
            push_s      = 1'b1;
            push_word_s = acc_d;
            // Clearing on push keeps unfilled lanes zero for a later flush.
            acc_d       = {OUT_W{1'b0}};
            lane_d      = 3'd0;
          end else begin
            lane_d = lane_q + 3'd1;
          end
        end else begin
          lane_d = lane_q;
        end
        if (frame_end) begin
          state_d = (lane_d != 3'd0) ? ST_FLUSH : ST_DRAIN;
        end else begin
          state_d = ST_PACK;
        end
      end
      ST_FLUSH: begin
        if (!full_s || pop_s) begin
          push_s      = 1'b1;
          push_word_s = acc_q;
          acc_d       = {OUT_W{1'b0}};
          lane_d      = 3'd0;
          state_d     = ST_DRAIN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (occ_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = ST_PACK;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_PACK;
      end
    endcase
  end

  // Two-entry output buffer with simultaneous push/pop support.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = push_word_s;
          occ_d  = 2'd1;
        end else begin
          buf1_d = push_word_s;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = push_word_s;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_word_s;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    vld_d = (occ_d != 2'd0);
  end

  // Per-frame word counter: cleared after frame_done, saturates at all-ones.
  always_comb begin
    if (done_q) begin
      words_d = {CNT_W{1'b0}};
    end else begin
      words_d = words_q;
    end
    if (push_s && (words_d != {CNT_W{1'b1}})) begin
      words_d = words_d + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      words_d = words_d;
    end
  end

  // State and output registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q <= ST_PACK;
      lane_q  <= 3'd0;
      acc_q   <= {OUT_W{1'b0}};
      buf0_q  <= {OUT_W{1'b0}};
      buf1_q  <= {OUT_W{1'b0}};
      occ_q   <= 2'd0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      words_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      occ_q   <= occ_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_vld      = vld_q;
  assign wr_data     = buf0_q;
  assign frame_done  = done_q;
  assign frame_words = words_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_wr_pix_pack.sv
module tb_wr_pix_pack;

  logic         wr_clk = 1'b0;
  logic         wr_rst_n;
  logic         pix_vld;
  logic [15:0]  pix_data;
  logic         frame_end;
  logic         pix_rdy;
  logic         wr_vld;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         frame_done;
  logic [15:0]  frame_words;
  logic         ovf;

  wr_pix_pack #(.IN_W(16), .OUT_W(128), .CNT_W(16)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .pix_vld(pix_vld), .pix_data(pix_data),
    .frame_end(frame_end), .pix_rdy(pix_rdy), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .frame_done(frame_done), .frame_words(frame_words), .ovf(ovf)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        fe;
    logic        r;
  } stim_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame state, pixels of the word being built, words waiting
  int           m_state;          // 0 packing, 1 flushing, 2 draining
  logic [15:0]  m_pix[$];
  logic [127:0] m_out[$];
  int           m_words;
  bit           m_ovf;
  bit           m_done;

  // Sampled DUT outputs and model expectations for the current cycle
  logic [3:0]   s_flags, e_flags;  // {wr_vld, pix_rdy, ovf, frame_done}
  logic [127:0] s_data, e_data;
  logic [15:0]  s_fw, e_fw;
  logic         e_vld, e_done;

  logic [127:0] obs[$];            // words actually handed downstream
  int           done_cnt;
  logic [15:0]  done_words;

  function automatic logic [127:0] pack_word();
    logic [127:0] w;
    w = '0;
    foreach (m_pix[i]) w[i*16 +: 16] = m_pix[i];
    return w;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pix.delete();
    m_out.delete();
    m_words = 0;
    m_ovf = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, advance model.
  task automatic cyc(input logic v, input logic [15:0] d, input logic fe, input logic r);
    bit pop, rdy, push, new_done;
    logic [127:0] w;
    @(negedge wr_clk);
    pix_vld = v; pix_data = d; frame_end = fe; wr_rdy = r;
    #1;
    s_flags = {wr_vld, pix_rdy, ovf, frame_done};
    s_data  = wr_data;
    s_fw    = frame_words;
    if (wr_vld && r) obs.push_back(wr_data);
    if (frame_done) begin
      done_cnt++;
      done_words = frame_words;
    end
    pop = (m_out.size() > 0) && r;
    rdy = (m_state == 0) && !((m_pix.size() == 7) && (m_out.size() == 2) && !pop);
    e_vld   = (m_out.size() > 0);
    e_data  = e_vld ? m_out[0] : '0;
    e_done  = m_done;
    e_fw    = 16'(m_words);
    e_flags = {e_vld, rdy, m_ovf, m_done};
    push = 1'b0;
    new_done = 1'b0;
    w = '0;
    if (v && !rdy) m_ovf = 1'b1;
    case (m_state)
      0: begin
        if (v && rdy) begin
          m_pix.push_back(d);
          if (m_pix.size() == 8) begin
            w = pack_word();
            m_pix.delete();
            push = 1'b1;
          end
        end
        if (fe) m_state = (m_pix.size() != 0) ? 1 : 2;
      end
      1: begin
        if ((m_out.size() < 2) || pop) begin
          w = pack_word();
          m_pix.delete();
          push = 1'b1;
          m_state = 2;
        end
      end
      default: begin
        if (m_out.size() == 0) begin
          new_done = 1'b1;
          m_state = 0;
        end
      end
    endcase
    if (m_done) m_words = 0;
    m_done = new_done;
    if (pop) void'(m_out.pop_front());
    if (push) begin
      m_out.push_back(w);
      if (m_words < 65535) m_words++;
    end
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    pix_vld = 1'b0; pix_data = '0; frame_end = 1'b0; wr_rdy = 1'b0;
    model_reset();
    obs.delete();
    done_cnt = 0;
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0;
    pix_vld = 1'b0; pix_data = '0; frame_end = 1'b0; wr_rdy = 1'b0;
    model_reset();
    obs.delete();
    done_cnt = 0;
    #3;
    n_vec++;
    if ({wr_vld, frame_done, ovf} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: vld/done/ovf got %b%b%b exp 000", wr_vld, frame_done, ovf);
    end
    n_vec++;
    if (wr_data !== 128'h0) begin
      n_err++; $display("FAIL reset_data: got %h exp 0", wr_data);
    end
    n_vec++;
    if (frame_words !== 16'h0) begin
      n_err++; $display("FAIL reset_words: got %0d exp 0", frame_words);
    end
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    #1;
    n_vec++;
    if (pix_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_pix_rdy: got %b exp 1", pix_rdy);
    end
  endtask

  task automatic test_ramp16();
    stim_t st[$];
    logic [127:0] w0;
    obs.delete(); done_cnt = 0;
    for (int i = 0; i < 16; i++) st.push_back({1'b1, 16'(i), 1'b0, 1'b1});
    st.push_back({1'b0, 16'h0, 1'b1, 1'b1});
    repeat (6) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      cyc(st[i].v, st[i].d, st[i].fe, st[i].r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL ramp16_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL ramp16_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
      if (e_done) begin
        n_vec++;
        if (s_fw !== e_fw) begin n_err++; $display("FAIL ramp16_fw step %0d: got %0d exp %0d", i, s_fw, e_fw); end
      end
    end
    w0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    n_vec++;
    if (obs.size() != 2) begin
      n_err++; $display("FAIL ramp16_count: got %0d words exp 2", obs.size());
    end else begin
      n_vec++;
      if (obs[0] !== w0) begin n_err++; $display("FAIL ramp16_word0: got %h exp %h", obs[0], w0); end
      n_vec++;
      if (obs[1][127:112] !== 16'h000F) begin n_err++; $display("FAIL ramp16_word1_top: got %h exp 000f", obs[1][127:112]); end
    end
    n_vec++;
    if (done_cnt != 1 || done_words !== 16'd2) begin
      n_err++; $display("FAIL ramp16_done: got %0d pulses words %0d exp 1 pulse words 2", done_cnt, done_words);
    end
  endtask

  task automatic test_ramp11();
    stim_t st[$];
    logic [127:0] w1;
    obs.delete(); done_cnt = 0;
    for (int i = 1; i <= 11; i++) st.push_back({1'b1, 16'(i), 1'b0, 1'b1});
    st.push_back({1'b0, 16'h0, 1'b1, 1'b1});
    repeat (6) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      cyc(st[i].v, st[i].d, st[i].fe, st[i].r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL ramp11_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL ramp11_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
      if (e_done) begin
        n_vec++;
        if (s_fw !== e_fw) begin n_err++; $display("FAIL ramp11_fw step %0d: got %0d exp %0d", i, s_fw, e_fw); end
      end
    end
    w1 = {80'h0, 16'h000B, 16'h000A, 16'h0009};
    n_vec++;
    if (obs.size() != 2) begin
      n_err++; $display("FAIL ramp11_count: got %0d words exp 2", obs.size());
    end else begin
      n_vec++;
      if (obs[1] !== w1) begin n_err++; $display("FAIL ramp11_pad_word: got %h exp %h", obs[1], w1); end
    end
    n_vec++;
    if (done_cnt != 1 || done_words !== 16'd2) begin
      n_err++; $display("FAIL ramp11_done: got %0d pulses words %0d exp 1 pulse words 2", done_cnt, done_words);
    end
  endtask

  task automatic test_fe_on_8th();
    stim_t st[$];
    obs.delete(); done_cnt = 0;
    for (int i = 0; i < 8; i++) st.push_back({1'b1, 16'(16'h0A00 + i), (i == 7) ? 1'b1 : 1'b0, 1'b1});
    repeat (5) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      cyc(st[i].v, st[i].d, st[i].fe, st[i].r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL fe8_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL fe8_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
      if (e_done) begin
        n_vec++;
        if (s_fw !== e_fw) begin n_err++; $display("FAIL fe8_fw step %0d: got %0d exp %0d", i, s_fw, e_fw); end
      end
    end
    n_vec++;
    if (obs.size() != 1 || done_cnt != 1 || done_words !== 16'd1) begin
      n_err++; $display("FAIL fe8_summary: got %0d words %0d pulses count %0d exp 1 1 1", obs.size(), done_cnt, done_words);
    end
  endtask

  task automatic test_stall_ovf();
    stim_t st[$];
    logic [127:0] exp_w;
    obs.delete(); done_cnt = 0;
    for (int i = 0; i < 24; i++) st.push_back({1'b1, 16'(16'h0100 + i), 1'b0, 1'b0});
    repeat (4) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    st.push_back({1'b0, 16'h0, 1'b1, 1'b1});
    repeat (6) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      cyc(st[i].v, st[i].d, st[i].fe, st[i].r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL stall_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL stall_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
      if (e_done) begin
        n_vec++;
        if (s_fw !== e_fw) begin n_err++; $display("FAIL stall_fw step %0d: got %0d exp %0d", i, s_fw, e_fw); end
      end
    end
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL stall_ovf: got %b exp 1", ovf); end
    n_vec++;
    if (obs.size() != 3) begin
      n_err++; $display("FAIL stall_count: got %0d words exp 3", obs.size());
    end else begin
      // Words 0 and 1 are whole; word 2 holds pixels 16..22 with pixel 23 dropped.
      for (int k = 0; k < 3; k++) begin
        exp_w = '0;
        for (int j = 0; j < 8; j++) if (k < 2 || j < 7) exp_w[j*16 +: 16] = 16'(16'h0100 + k*8 + j);
        n_vec++;
        if (obs[k] !== exp_w) begin n_err++; $display("FAIL stall_word%0d: got %h exp %h", k, obs[k], exp_w); end
      end
    end
  endtask

  task automatic test_toggle();
    stim_t st[$];
    logic [127:0] exp_w, prev_data;
    bit prev_stall;
    do_reset();
    obs.delete(); done_cnt = 0;
    for (int i = 0; i < 48; i++) st.push_back({1'b1, 16'(16'h2000 + i), 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
    for (int i = 0; i < 8; i++) st.push_back({1'b0, 16'h0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
    st.push_back({1'b0, 16'h0, 1'b1, 1'b1});
    repeat (8) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    prev_stall = 1'b0;
    prev_data = '0;
    for (int i = 0; i < st.size(); i++) begin
      cyc(st[i].v, st[i].d, st[i].fe, st[i].r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL toggle_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL toggle_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
      if (prev_stall) begin
        n_vec++;
        if (s_data !== prev_data) begin n_err++; $display("FAIL toggle_stable step %0d: got %h exp %h", i, s_data, prev_data); end
      end
      prev_stall = s_flags[3] && !st[i].r;
      prev_data = s_data;
    end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL toggle_ovf: got %b exp 0", ovf); end
    n_vec++;
    if (obs.size() != 6) begin
      n_err++; $display("FAIL toggle_count: got %0d words exp 6", obs.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        for (int j = 0; j < 8; j++) exp_w[j*16 +: 16] = 16'(16'h2000 + k*8 + j);
        n_vec++;
        if (obs[k] !== exp_w) begin n_err++; $display("FAIL toggle_word%0d: got %h exp %h", k, obs[k], exp_w); end
      end
    end
    n_vec++;
    if (done_cnt != 1 || done_words !== 16'd6) begin
      n_err++; $display("FAIL toggle_done: got %0d pulses words %0d exp 1 pulse words 6", done_cnt, done_words);
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$];
    logic [127:0] exp_w;
    for (int i = 0; i < 13; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    @(negedge wr_clk);
    pix_vld = 1'b0; frame_end = 1'b0; wr_rdy = 1'b0;
    #1;
    n_vec++;
    if (wr_vld !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_vld: got %b exp 1", wr_vld); end
    #2;
    wr_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wr_vld, frame_done, ovf} !== 3'b000 || wr_data !== 128'h0) begin
      n_err++; $display("FAIL rstmid_clear: vld/done/ovf got %b%b%b data %h exp 000 data 0", wr_vld, frame_done, ovf, wr_data);
    end
    model_reset();
    obs.delete(); done_cnt = 0;
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) st.push_back({1'b1, 16'(16'h3000 + i), 1'b0, 1'b1});
    repeat (4) st.push_back({1'b0, 16'h0, 1'b0, 1'b1});
    for (int i = 0; i < st.size(); i++) begin
      cyc(st[i].v, st[i].d, st[i].fe, st[i].r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL rstmid_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL rstmid_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
    end
    for (int j = 0; j < 8; j++) exp_w[j*16 +: 16] = 16'(16'h3000 + j);
    n_vec++;
    if (obs.size() != 1) begin
      n_err++; $display("FAIL rstmid_count: got %0d words exp 1", obs.size());
    end else begin
      n_vec++;
      if (obs[0] !== exp_w) begin n_err++; $display("FAIL rstmid_word: got %h exp %h", obs[0], exp_w); end
    end
  endtask

  task automatic test_random();
    logic v, fe, r;
    int lim;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      lim = ((i / 100) % 2 == 1) ? 2 : 8;
      v  = ($urandom_range(0, 3) != 0);
      fe = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 9) < lim);
      if (i >= 780) begin v = 1'b0; fe = (i == 780); r = 1'b1; end
      cyc(v, 16'($urandom), fe, r);
      n_vec++;
      if (s_flags !== e_flags) begin
        n_err++; $display("FAIL random_flags step %0d: vld/rdy/ovf/done got %b exp %b", i, s_flags, e_flags);
      end
      if (e_vld) begin
        n_vec++;
        if (s_data !== e_data) begin n_err++; $display("FAIL random_data step %0d: got %h exp %h", i, s_data, e_data); end
      end
      if (e_done) begin
        n_vec++;
        if (s_fw !== e_fw) begin n_err++; $display("FAIL random_fw step %0d: got %0d exp %0d", i, s_fw, e_fw); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp16();
    test_ramp11();
    test_fe_on_8th();
    test_stall_ovf();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wr_pix_pack.md
Name: wr_pix_pack

Overview:
- Write-side counterpart of the DDR read-path FIFO: packs 16-bit camera pixels into 128-bit words for the DDR write FIFO.
- Single clock domain (camera pixel clock). Sits between the camera capture logic and the async write FIFO feeding the DDR write master.
- Provides per-frame flush with zero-padding, a frame-done pulse with word count, and overflow detection, because the camera cannot be stalled.

Parameters:
- IN_W, 16, pixel width; OUT_W must equal 8*IN_W.
- OUT_W, 128, packed word width.
- CNT_W, 16, width of the per-frame word counter.

Ports:
- wr_clk  in  1  pixel/write clock.
- wr_rst_n  in  1  asynchronous active-low reset.
- pix_vld  in  1  pixel strobe from capture.
- pix_data  in  IN_W  pixel.
- frame_end  in  1  one-cycle pulse; the last pixel of the frame is on or before this cycle.
- pix_rdy  out  1  combinational; packer can accept a pixel this cycle.
- wr_vld  out  1  packed word valid.
- wr_data  out  OUT_W  packed word; pixel 0 in [15:0], pixel 7 in [127:112].
- wr_rdy  in  1  downstream (write FIFO not full).
- frame_done  out  1  one-cycle pulse when the frame is fully drained.
- frame_words  out  CNT_W  words pushed in the frame; valid while frame_done=1.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset values:
  - wr_vld=0, wr_data=0, frame_done=0, frame_words=0, ovf=0.
  - lane_cnt=0, accumulator=0, output buffer empty, state=PACK.
  - pix_rdy=1 once reset is released.
- Accumulator: lane_cnt is 3 bits (0..7). An accepted pixel (pix_vld & pix_rdy) is written to lane lane_cnt, and lane_cnt increments modulo 8.
- Word push: the accepted pixel at lane 7 pushes the full word into a 2-entry output buffer. Latency from that 8th pixel to wr_vld is 1 cycle when the buffer is empty.
- Output handshake:
  - wr_vld/wr_data come from the head entry; a pop occurs on wr_vld & wr_rdy.
  - wr_data holds stable while wr_vld & !wr_rdy.
  - A push and a pop in the same cycle are allowed, including when the buffer is full.
- pix_rdy = (state==PACK) & !(lane_cnt==7 & buf_full & !(wr_vld & wr_rdy)).
- Overflow: pix_vld & !pix_rdy drops the pixel, sets ovf=1, and leaves lane_cnt unchanged. ovf is cleared only by reset.
- State machine:
  - PACK: normal packing. On frame_end, any pixel accepted in the same cycle is included first. Then go to FLUSH if lane_cnt (after that pixel) != 0, else to DRAIN.
  - FLUSH: pix_rdy=0. When the buffer has space (or a pop occurs this cycle), push the accumulator with unfilled lanes zeroed, set lane_cnt=0, go to DRAIN.
  - DRAIN: pix_rdy=0. When the buffer is empty, pulse frame_done for 1 cycle, present frame_words, go to PACK.
- frame_words:
  - Increments on every push, including the padded word, and saturates at all-ones.
  - Cleared the cycle after frame_done.
  - A frame_end with no pushed words gives frame_done with frame_words=0.
- frame_end outside PACK is ignored and does not set ovf. A pix_vld in FLUSH/DRAIN sets ovf.
- Reset mid-operation: everything returns to reset values immediately. Buffered and partial words are discarded.

Test Plan:
- Ramp 16 pixels 0x0000..0x000F, wr_rdy=1, then frame_end:
  - 2 words; first wr_data=0x0007_0006_0005_0004_0003_0002_0001_0000, second word holds 0x000F in [127:112].
  - frame_done with frame_words=2; no pad word.
- Ramp 11 pixels 0x0001..0x000B then frame_end:
  - second word = pixels 0x0009..0x000B in lanes 0..2, lanes 3..7 zero.
  - frame_done with frame_words=2.
- wr_rdy=0, 24 continuous pixels:
  - buffer fills after 16; pix_rdy drops at lane_cnt=7; 8th pixel of third word dropped; ovf=1.
  - after wr_rdy=1, 2 words drain, unchanged and in order.
- wr_rdy toggling 1/0 every cycle with continuous pixels:
  - no ovf; all words correct and in order.
  - wr_data stable while stalled.
- frame_end on the same cycle as the 8th pixel:
  - word pushed normally, no pad word.
  - frame_done once the buffer is empty; frame_words=1.
- Assert wr_rst_n=0 with 1 buffered word and lane_cnt=5:
  - wr_vld=0 immediately; after release the next 8 pixels produce exactly one word with no stale data.
